// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both
// sides, registered status flags and an accumulator that can stand in for
// operand A so dependent operations chain back-to-back without stalling.
// The opcode package is shared with the register file.

package ALU_REGFILE_Defs;
   typedef enum logic [2:0] {
      ADD_OP   = 3'd0,
      SUB_OP   = 3'd1,
      SUBA_OP  = 3'd2,
      ORAB_OP  = 3'd3,
      ANDAB_OP = 3'd4,
      NOTAB_OP = 3'd5,
      EXOR_OP  = 3'd6,
      EXNOR_OP = 3'd7
   } aluop_t;
endpackage : ALU_REGFILE_Defs

module alu_pipe
   import ALU_REGFILE_Defs::*;
#(
   parameter int ALU_WIDTH = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 In_Valid,
   output logic                 In_Ready,
   input  logic [ALU_WIDTH-1:0] A_In,
   input  logic [ALU_WIDTH-1:0] B_In,
   input  logic                 Carry_In,
   input  aluop_t               Opcode,
   input  logic                 Use_Acc,
   input  logic                 Acc_Clear,
   output logic                 Out_Valid,
   input  logic                 Out_Ready,
   output logic [ALU_WIDTH:0]   ALU_Out,
   output logic                 Zero,
   output logic                 Negative,
   output logic                 Overflow,
   output logic [ALU_WIDTH-1:0] Acc_Out
);

   localparam int W = ALU_WIDTH;

   // Stage 1: captured request
   logic         r_s1_valid;
   logic [W-1:0] r_s1_a;
   logic [W-1:0] r_s1_b;
   logic         r_s1_cin;
   aluop_t       r_s1_op;
   logic         r_s1_use_acc;

   // Stage 2: registered result, flags and accumulator
   logic         r_s2_valid;
   logic [W:0]   r_alu_out;
   logic         r_zero;
   logic         r_negative;
   logic         r_overflow;
   logic [W-1:0] r_acc;

   // Handshake
   logic         w_s2_ready;
   logic         w_s1_adv;
   logic         w_in_ready;
   logic         w_s1_load;

   // Datapath
   logic [W-1:0] w_op_a;
   logic [W-1:0] w_op_b_add;
   logic         w_cin_eff;
   logic         w_is_arith;
   logic [W:0]   w_sum;
   logic [W:0]   w_result;
   logic         w_zero;
   logic         w_negative;
   logic         w_overflow;

   // Handshake: S2 can take a new result when empty or draining this cycle;
   // S1 can take a new request when empty or moving forward this cycle.
   always_comb begin
      w_s2_ready = !r_s2_valid || Out_Ready;
      w_s1_adv   = r_s1_valid && w_s2_ready;
      w_in_ready = !r_s1_valid || w_s1_adv;
      w_s1_load  = In_Valid && w_in_ready;
   end

   // Operand selection, W+1-bit arithmetic, logic ops and flag derivation
   // for the request held in S1. The accumulator read here is the value
   // before this edge's update, which is what makes chaining hazard-free.
   // NOTE: every signal gets a default before the case so no path infers a latch.
   always_comb begin
      w_op_a     = r_s1_use_acc ? r_acc : r_s1_a;
      w_op_b_add = r_s1_b;
      w_cin_eff  = r_s1_cin;
      w_is_arith = 1'b0;
      w_result   = '0;

      case (r_s1_op)
         ADD_OP: begin
            w_is_arith = 1'b1;
         end
         SUB_OP: begin
            w_op_b_add = ~r_s1_b;
            w_is_arith = 1'b1;
         end
         SUBA_OP: begin
            w_op_b_add = ~r_s1_b;
            w_cin_eff  = !r_s1_cin;
            w_is_arith = 1'b1;
         end
         default: ;
      endcase

      // Carry out lands in bit W, so nothing is lost on wrap-around.
      w_sum = {1'b0, w_op_a} + {1'b0, w_op_b_add} + {{W{1'b0}}, w_cin_eff};

      case (r_s1_op)
         ADD_OP, SUB_OP, SUBA_OP: w_result = w_sum;
         ORAB_OP:                 w_result = {1'b0, w_op_a | r_s1_b};
         ANDAB_OP:                w_result = {1'b0, w_op_a & r_s1_b};
         NOTAB_OP:                w_result = {1'b0, ~w_op_a & r_s1_b};
         EXOR_OP:                 w_result = {1'b0, w_op_a ^ r_s1_b};
         EXNOR_OP:                w_result = {1'b0, w_op_a ~^ r_s1_b};
         default:                 w_result = '0;
      endcase

      w_zero     = (w_result[W-1:0] == '0);
      w_negative = w_result[W-1];
      w_overflow = w_is_arith
                   && (w_op_a[W-1] == w_op_b_add[W-1])
                   && (w_result[W-1] != w_op_a[W-1]);
   end

   // S1 occupancy: set on accept, cleared when the request moves into S2.
   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_load) begin
         r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // S1 payload capture on accept.
   // NOTE: payload registers are not reset; r_s1_valid alone qualifies them.
   always_ff @(posedge Clock) begin
      if (w_s1_load) begin
         r_s1_a       <= A_In;
         r_s1_b       <= B_In;
         r_s1_cin     <= Carry_In;
         r_s1_op      <= Opcode;
         r_s1_use_acc <= Use_Acc;
      end
   end

   // S2: load result and flags on transfer, hold while stalled, empty on drain.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_s2_valid <= 1'b0;
         r_alu_out  <= '0;
         r_zero     <= 1'b0;
         r_negative <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_valid <= 1'b1;
         r_alu_out  <= w_result;
         r_zero     <= w_zero;
         r_negative <= w_negative;
         r_overflow <= w_overflow;
      end else if (Out_Ready) begin
         r_s2_valid <= 1'b0;
      end
   end

   // Accumulator: follows every S2 load; a clear wins over a same-edge load.
   always_ff @(posedge Clock) begin
      if (Reset || Acc_Clear) begin
         r_acc <= '0;
      end else if (w_s1_adv) begin
         r_acc <= w_result[W-1:0];
      end
   end

   assign In_Ready  = w_in_ready;
   assign Out_Valid = r_s2_valid;
   assign ALU_Out   = r_alu_out;
   assign Zero      = r_zero;
   assign Negative  = r_negative;
   assign Overflow  = r_overflow;
   assign Acc_Out   = r_acc;

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: table-driven single ops, chaining, backpressure,
// reset flush, width sweep, then randomized traffic against a scoreboard
// driven by an arithmetic reference model.

module tb_alu_pipe;
   import ALU_REGFILE_Defs::*;

   logic Clock;
   logic Reset;
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Shared request fields
   aluop_t op;
   logic   cin;

   // W = 8 instance
   logic       in_valid, in_ready, use_acc, acc_clear, out_valid, out_ready;
   logic       zero, neg, ovf;
   logic [7:0] a, b, acc_out;
   logic [8:0] alu_out;

   alu_pipe #(.ALU_WIDTH(8)) u_dut8 (
      .Clock(Clock), .Reset(Reset), .In_Valid(in_valid), .In_Ready(in_ready),
      .A_In(a), .B_In(b), .Carry_In(cin), .Opcode(op), .Use_Acc(use_acc),
      .Acc_Clear(acc_clear), .Out_Valid(out_valid), .Out_Ready(out_ready),
      .ALU_Out(alu_out), .Zero(zero), .Negative(neg), .Overflow(ovf),
      .Acc_Out(acc_out)
   );

   // W = 4 instance
   logic       in_valid4, in_ready4, out_valid4, zero4, neg4, ovf4;
   logic [3:0] a4, b4, acc4;
   logic [4:0] alu4;

   alu_pipe #(.ALU_WIDTH(4)) u_dut4 (
      .Clock(Clock), .Reset(Reset), .In_Valid(in_valid4), .In_Ready(in_ready4),
      .A_In(a4), .B_In(b4), .Carry_In(cin), .Opcode(op), .Use_Acc(1'b0),
      .Acc_Clear(1'b0), .Out_Valid(out_valid4), .Out_Ready(1'b1),
      .ALU_Out(alu4), .Zero(zero4), .Negative(neg4), .Overflow(ovf4),
      .Acc_Out(acc4)
   );

   // W = 16 instance
   logic        in_valid16, in_ready16, out_valid16, zero16, neg16, ovf16;
   logic [15:0] a16, b16, acc16;
   logic [16:0] alu16;

   alu_pipe #(.ALU_WIDTH(16)) u_dut16 (
      .Clock(Clock), .Reset(Reset), .In_Valid(in_valid16), .In_Ready(in_ready16),
      .A_In(a16), .B_In(b16), .Carry_In(cin), .Opcode(op), .Use_Acc(1'b0),
      .Acc_Clear(1'b0), .Out_Valid(out_valid16), .Out_Ready(1'b1),
      .ALU_Out(alu16), .Zero(zero16), .Negative(neg16), .Overflow(ovf16),
      .Acc_Out(acc16)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      aluop_t     op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [8:0] res;
      logic       z;
      logic       n;
      logic       v;
   } vec_t;

   typedef struct {
      longint unsigned res;
      bit              z;
      bit              n;
      bit              v;
   } exp_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Reference model: the ALU rules written as plain integer arithmetic.
   function automatic exp_t model(input aluop_t o, input longint unsigned x_in,
                                  input longint unsigned y_in, input bit c, input int w);
      exp_t            e;
      longint unsigned m  = (64'd1 << w) - 1;
      longint unsigned x  = x_in & m;
      longint unsigned y  = y_in & m;
      longint unsigned yb = (o == ADD_OP) ? y : (~y & m);
      bit arith = (o == ADD_OP) || (o == SUB_OP) || (o == SUBA_OP);
      case (o)
         ADD_OP, SUB_OP: e.res = x + yb + c;
         SUBA_OP:        e.res = x + yb + (c ? 0 : 1);
         ORAB_OP:        e.res = x | y;
         ANDAB_OP:       e.res = x & y;
         NOTAB_OP:       e.res = (~x & m) & y;
         EXOR_OP:        e.res = x ^ y;
         default:        e.res = ~(x ^ y) & m;
      endcase
      e.res = e.res % (64'd1 << (w + 1));
      e.z = ((e.res & m) == 0);
      e.n = ((e.res >> (w - 1)) & 1) != 0;
      e.v = arith && (((x >> (w - 1)) & 1) == ((yb >> (w - 1)) & 1))
                  && (((e.res >> (w - 1)) & 1) != ((x >> (w - 1)) & 1));
      return e;
   endfunction

   vec_t            vecs[11];
   vec_t            bp[4];
   exp_t            q[$];
   exp_t            e;
   longint unsigned model_acc;
   int              idx, got;

   initial begin
      Reset = 1'b1;  op = ADD_OP;  cin = 1'b0;
      in_valid = 1'b0; use_acc = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; in_valid4 = 1'b0; a4 = '0; b4 = '0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0;

      vecs[0]  = '{ADD_OP,   8'hFF, 8'h01, 1'b1, 9'h101, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{ADD_OP,   8'h7F, 8'h01, 1'b0, 9'h080, 1'b0, 1'b1, 1'b1};
      vecs[2]  = '{SUB_OP,   8'h05, 8'h05, 1'b1, 9'h100, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{SUBA_OP,  8'h05, 8'h03, 1'b0, 9'h102, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{SUB_OP,   8'h80, 8'h01, 1'b1, 9'h17F, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{ORAB_OP,  8'hF0, 8'h0F, 1'b1, 9'h0FF, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{ANDAB_OP, 8'hF0, 8'h3C, 1'b0, 9'h030, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{NOTAB_OP, 8'h0F, 8'hFF, 1'b0, 9'h0F0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{EXOR_OP,  8'hAA, 8'hFF, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{EXNOR_OP, 8'hAA, 8'hFF, 1'b0, 9'h0AA, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{ANDAB_OP, 8'hAA, 8'h55, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0};

      bp[0] = '{ORAB_OP,  8'hF0, 8'h0F, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0};
      bp[1] = '{ANDAB_OP, 8'hF0, 8'h3C, 1'b0, 9'h030, 1'b0, 1'b0, 1'b0};
      bp[2] = '{EXOR_OP,  8'hAA, 8'hFF, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0};
      bp[3] = '{EXNOR_OP, 8'hAA, 8'hFF, 1'b0, 9'h0AA, 1'b0, 1'b1, 1'b0};

      // Reset state
      step(); step();
      check("rst_out_valid", out_valid, 0);
      check("rst_alu_out", alu_out, 0);
      check("rst_flags", {zero, neg, ovf}, 0);
      check("rst_acc", acc_out, 0);
      Reset = 1'b0;
      #1 check("rst_in_ready", in_ready, 1);

      // Table-driven single operations: result exactly one edge after accept
      foreach (vecs[i]) begin
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_early", i), out_valid, 0);
         step();
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_out", i), alu_out, vecs[i].res);
         check($sformatf("vec%0d_znv", i), {zero, neg, ovf},
               {vecs[i].z, vecs[i].n, vecs[i].v});
      end

      // Back-to-back chaining through the accumulator
      for (int pass = 0; pass < 2; pass++) begin
         op = ADD_OP; cin = 1'b0; use_acc = 1'b0; a = 8'd3; b = 8'd4; in_valid = 1'b1;
         step();
         use_acc = 1'b1; a = 8'hEE; b = 8'd10;
         step();
         in_valid = 1'b0; use_acc = 1'b0;
         check($sformatf("chain%0d_first", pass), alu_out, 9'h007);
         acc_clear = (pass == 1);
         step();
         acc_clear = 1'b0;
         check($sformatf("chain%0d_valid", pass), out_valid, 1);
         check($sformatf("chain%0d_second", pass), alu_out, 9'h011);
         check($sformatf("chain%0d_acc", pass), acc_out, (pass == 1) ? 8'h00 : 8'h11);
      end

      // Backpressure: two accepted while stalled, then in-order drain
      step();
      out_ready = 1'b0; idx = 0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) check("bp_hold", alu_out, 9'h0FF);
         in_valid = (idx < 4);
         if (idx < 4) begin
            op = bp[idx].op; a = bp[idx].a; b = bp[idx].b; cin = 1'b0;
         end
         #1 if (in_valid && in_ready) idx++;
         step();
      end
      check("bp_accepted", idx, 2);
      check("bp_in_ready", in_ready, 0);
      out_ready = 1'b1; got = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         if (out_valid) begin
            check($sformatf("bp_out%0d", got), alu_out, bp[got].res);
            got++;
         end
         in_valid = (idx < 4);
         if (idx < 4) begin
            op = bp[idx].op; a = bp[idx].a; b = bp[idx].b;
         end
         #1 if (in_valid && in_ready) idx++;
         step();
      end
      check("bp_count", got, 4);
      in_valid = 1'b0;

      // Reset with both stages full
      out_ready = 1'b0; op = ORAB_OP; a = 8'h01; b = 8'h02; in_valid = 1'b1;
      step(); step(); step();
      check("flush_full", in_ready, 0);
      Reset = 1'b1; in_valid = 1'b0;
      step();
      check("flush_out_valid", out_valid, 0);
      check("flush_acc", acc_out, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_alu_out", alu_out, 0);
      Reset = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check("flush_stale", out_valid, 0);
      end

      // Width sweep: all-ones + 1 wraps into the carry bit
      op = ADD_OP; cin = 1'b0;
      a4 = 4'hF; b4 = 4'h1; a16 = 16'hFFFF; b16 = 16'h0001;
      in_valid4 = 1'b1; in_valid16 = 1'b1;
      #1 check("w4_in_ready", in_ready4, 1);
      step();
      in_valid4 = 1'b0; in_valid16 = 1'b0;
      step();
      check("w4_valid", out_valid4, 1);
      check("w4_add", alu4, 5'h10);
      check("w4_zero", zero4, 1);
      check("w4_ovf", ovf4, 0);
      check("w4_acc", acc4, 0);
      check("w16_valid", out_valid16, 1);
      check("w16_add", alu16, 17'h10000);
      check("w16_zero", zero16, 1);
      check("w16_flags", {neg16, ovf16, acc16}, 0);
      check("w16_in_ready", in_ready16, 1);
      op = NOTAB_OP; a4 = 4'h5; b4 = 4'hF; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      step();
      check("w4_notab", alu4, 5'h0A);
      check("w4_notab_neg", neg4, 1);

      // Randomized traffic against the model; chained ops see the previous
      // op's result in issue order
      Reset = 1'b1;
      step();
      Reset = 1'b0; model_acc = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("rand_spurious", out_valid, 0);
            end else begin
               check("rand_out", alu_out, q[0].res);
               check("rand_znv", {zero, neg, ovf}, {q[0].z, q[0].n, q[0].v});
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0) && (cyc < 1980);
         op        = aluop_t'($urandom_range(0, 7));
         a         = 8'($urandom);
         b         = 8'($urandom);
         cin       = 1'($urandom);
         use_acc   = 1'($urandom);
         #1;
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            e = model(op, use_acc ? model_acc : longint'(a), longint'(b), cin, 8);
            model_acc = e.res & 64'hFF;
            q.push_back(e);
         end
         step();
      end
      check("rand_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_alu_pipe
